// File: rtl/reg_bank_param.sv
// Parametrised register file with two registered read ports, one bypassed write port,
// optional hardwired-zero location and a per-register busy scoreboard for RAW hazard checks.
module reg_bank_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rstBar,
    input  logic             csBar,
    input  logic             rdEn,
    input  logic [AW-1:0]    selSrc0,
    input  logic [AW-1:0]    selSrc1,
    output logic [XLEN-1:0]  src0,
    output logic [XLEN-1:0]  src1,
    output logic             srcValid,
    output logic             src0Busy,
    output logic             src1Busy,
    input  logic             wrEn,
    input  logic [AW-1:0]    selDst,
    input  logic [XLEN-1:0]  dst,
    input  logic             rsvEn,
    input  logic [AW-1:0]    selRsv,
    output logic [NREGS-1:0] busyMask
);

    localparam logic [AW:0] NREGS_A = (AW + 1)'(NREGS);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  src0_q, src0_d, src1_q, src1_d;
    logic             src0_busy_q, src0_busy_d, src1_busy_q, src1_busy_d;
    logic             src_valid_q, src_valid_d;
    logic             wr_ok, rsv_ok, rd_ok;

    // Out-of-range and (optionally) zero addresses behave as a constant-zero, never-busy location.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        addr_ok = ({1'b0, a} < NREGS_A) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        wr_ok       = !csBar && wrEn  && addr_ok(selDst);
        rsv_ok      = !csBar && rsvEn && addr_ok(selRsv);
        rd_ok       = !csBar && rdEn;
        mem_d       = mem_q;
        busy_d      = busy_q;
        src0_d      = src0_q;
        src1_d      = src1_q;
        src0_busy_d = src0_busy_q;
        src1_busy_d = src1_busy_q;
        src_valid_d = 1'b0;

        if (wr_ok) begin
            mem_d[selDst]  = dst;
            busy_d[selDst] = 1'b0;
        end
        // Reserve applied after the write clear: a newer producer keeps the register busy.
        if (rsv_ok) begin
            busy_d[selRsv] = 1'b1;
        end

        // Reading next-state storage gives write-to-read bypass and post-update busy for free.
        if (rd_ok) begin
            src_valid_d = 1'b1;
            src0_d      = addr_ok(selSrc0) ? mem_d[selSrc0]  : '0;
            src1_d      = addr_ok(selSrc1) ? mem_d[selSrc1]  : '0;
            src0_busy_d = addr_ok(selSrc0) ? busy_d[selSrc0] : 1'b0;
            src1_busy_d = addr_ok(selSrc1) ? busy_d[selSrc1] : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstBar) begin
        if (!rstBar) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q      <= '0;
            src0_q      <= '0;
            src1_q      <= '0;
            src0_busy_q <= 1'b0;
            src1_busy_q <= 1'b0;
            src_valid_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            busy_q      <= busy_d;
            src0_q      <= src0_d;
            src1_q      <= src1_d;
            src0_busy_q <= src0_busy_d;
            src1_busy_q <= src1_busy_d;
            src_valid_q <= src_valid_d;
        end
    end

    assign src0     = src0_q;
    assign src1     = src1_q;
    assign src0Busy = src0_busy_q;
    assign src1Busy = src1_busy_q;
    assign srcValid = src_valid_q;
    assign busyMask = busy_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: behavioural model checked every cycle on the default build,
// plus directed checks on a 64-bit, 24-entry build.
module tb_reg_bank_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstBar, csBar, rdEn, wrEn, rsvEn;
    logic [4:0]  selSrc0, selSrc1, selDst, selRsv;
    logic [31:0] dst, src0, src1, busyMask;
    logic        srcValid, src0Busy, src1Busy;

    logic        p_csBar, p_rdEn, p_wrEn, p_rsvEn;
    logic [4:0]  p_selSrc0, p_selSrc1, p_selDst, p_selRsv;
    logic [63:0] p_dst, p_src0, p_src1;
    logic        p_srcValid, p_src0Busy, p_src1Busy;
    logic [23:0] p_busyMask;

    reg_bank_param dut (
        .clk(clk), .rstBar(rstBar), .csBar(csBar), .rdEn(rdEn),
        .selSrc0(selSrc0), .selSrc1(selSrc1), .src0(src0), .src1(src1),
        .srcValid(srcValid), .src0Busy(src0Busy), .src1Busy(src1Busy),
        .wrEn(wrEn), .selDst(selDst), .dst(dst), .rsvEn(rsvEn), .selRsv(selRsv),
        .busyMask(busyMask)
    );

    reg_bank_param #(.XLEN(64), .NREGS(24), .ZERO_REG(1)) dut_p (
        .clk(clk), .rstBar(rstBar), .csBar(p_csBar), .rdEn(p_rdEn),
        .selSrc0(p_selSrc0), .selSrc1(p_selSrc1), .src0(p_src0), .src1(p_src1),
        .srcValid(p_srcValid), .src0Busy(p_src0Busy), .src1Busy(p_src1Busy),
        .wrEn(p_wrEn), .selDst(p_selDst), .dst(p_dst), .rsvEn(p_rsvEn), .selRsv(p_selRsv),
        .busyMask(p_busyMask)
    );

    // Reference model: what each register holds and which are reserved.
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic [31:0] m_s0, m_s1;
    logic        m_b0, m_b1, m_v;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ok(input logic [4:0] a);
        return (a != 5'd0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0; m_s0 = '0; m_s1 = '0; m_b0 = 0; m_b1 = 0; m_v = 0;
    endtask

    task automatic model_step();
        if (!rstBar) return;
        if (csBar) begin
            m_v = 1'b0;
            return;
        end
        if (wrEn && m_ok(selDst)) begin
            m_mem[selDst]  = dst;
            m_busy[selDst] = 1'b0;
        end
        if (rsvEn && m_ok(selRsv)) m_busy[selRsv] = 1'b1;
        if (rdEn) begin
            m_s0 = m_ok(selSrc0) ? m_mem[selSrc0]  : 32'd0;
            m_s1 = m_ok(selSrc1) ? m_mem[selSrc1]  : 32'd0;
            m_b0 = m_ok(selSrc0) ? m_busy[selSrc0] : 1'b0;
            m_b1 = m_ok(selSrc1) ? m_busy[selSrc1] : 1'b0;
            m_v  = 1'b1;
        end else begin
            m_v = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("src0", 64'(src0), 64'(m_s0));
            chk("src1", 64'(src1), 64'(m_s1));
            chk("src0Busy", 64'(src0Busy), 64'(m_b0));
            chk("src1Busy", 64'(src1Busy), 64'(m_b1));
            chk("srcValid", 64'(srcValid), 64'(m_v));
            chk("busyMask", 64'(busyMask), 64'(m_busy));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1 model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit cs_b, input bit rd, input logic [4:0] s0, input logic [4:0] s1,
                         input bit wr, input logic [4:0] d, input logic [31:0] data,
                         input bit rsv, input logic [4:0] r);
        csBar = cs_b; rdEn = rd; selSrc0 = s0; selSrc1 = s1;
        wrEn = wr; selDst = d; dst = data; rsvEn = rsv; selRsv = r;
        cyc();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rstBar = 1'b0;
        model_reset();
        repeat (n) cyc();
        rstBar = 1'b1;
    endtask

    task automatic pcyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic random_traffic(input int n);
        logic [4:0] a [4];
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++)
                a[j] = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 499) == 0) begin
                rdEn = 1'b1;
                do_reset(1);
            end else begin
                drive(($urandom_range(0, 7) == 0), 1'($urandom), a[0], a[1],
                      1'($urandom), a[2], $urandom, ($urandom_range(0, 2) == 0), a[3]);
            end
        end
    endtask

    initial begin
        rstBar = 1'b0;
        csBar = 0; rdEn = 0; wrEn = 0; rsvEn = 0;
        selSrc0 = 0; selSrc1 = 0; selDst = 0; selRsv = 0; dst = 0;
        p_csBar = 0; p_rdEn = 0; p_wrEn = 0; p_rsvEn = 0;
        p_selSrc0 = 0; p_selSrc1 = 0; p_selDst = 0; p_selRsv = 0; p_dst = 0;
        model_reset();
        #1;
        cmp_en = 1'b1;
        do_reset(3);
        chk("reset_busyMask", 64'(busyMask), 64'd0);
        chk("reset_srcValid", 64'(srcValid), 64'd0);

        random_traffic(200);

        // Reset asserted mid-run with a read pending.
        drive(0, 1, 5'd1, 5'd2, 1, 5'd4, 32'hA5A5_0001, 1, 5'd5);
        rdEn = 1'b1;
        do_reset(2);
        chk("midreset_srcValid", 64'(srcValid), 64'd0);
        chk("midreset_busyMask", 64'(busyMask), 64'd0);
        drive(0, 1, 5'd5, 5'd31, 0, 0, 0, 0, 0);
        chk("rst_rd_src0", 64'(src0), 64'd0);
        chk("rst_rd_src1", 64'(src1), 64'd0);
        chk("rst_rd_busy", 64'({src0Busy, src1Busy}), 64'd0);
        chk("rst_rd_valid", 64'(srcValid), 64'd1);
        idle();
        chk("idle_valid", 64'(srcValid), 64'd0);

        // Write with same-cycle bypass, then read from storage.
        drive(0, 1, 5'd7, 5'd0, 1, 5'd7, 32'hDEAD_BEEF, 0, 0);
        chk("bypass_src0", 64'(src0), 64'h0000_0000_DEAD_BEEF);
        chk("model_bypass", 64'(m_s0), 64'h0000_0000_DEAD_BEEF);
        drive(0, 1, 5'd0, 5'd7, 0, 0, 0, 0, 0);
        chk("stored_src1", 64'(src1), 64'h0000_0000_DEAD_BEEF);

        // Hardwired zero register.
        drive(0, 1, 5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0);
        chk("zero_bypass", 64'(src0), 64'd0);
        drive(0, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        chk("zero_src0", 64'(src0), 64'd0);
        chk("zero_busy", 64'(src0Busy), 64'd0);
        chk("zero_mask0", 64'(busyMask[0]), 64'd0);

        // Scoreboard reserve / clear / reserve-wins.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd3);
        chk("rsv_mask3", 64'(busyMask[3]), 64'd1);
        drive(0, 1, 5'd3, 5'd0, 0, 0, 0, 0, 0);
        chk("rsv_src0Busy", 64'(src0Busy), 64'd1);
        drive(0, 0, 0, 0, 1, 5'd3, 32'h12, 0, 0);
        chk("wr_clears3", 64'(busyMask[3]), 64'd0);
        drive(0, 0, 0, 0, 1, 5'd3, 32'h12, 1, 5'd3);
        chk("rsv_wins3", 64'(busyMask[3]), 64'd1);
        drive(0, 1, 5'd3, 5'd3, 0, 0, 0, 0, 0);
        chk("rsv_wr_data", 64'(src0), 64'h12);
        chk("rsv_wr_busy", 64'(src1Busy), 64'd1);
        chk("model_busy", 64'(m_busy), 64'h8);

        // Chip select high: everything ignored, outputs hold.
        drive(1, 1, 5'd9, 5'd9, 1, 5'd9, 32'h55, 1, 5'd9);
        chk("cs_valid", 64'(srcValid), 64'd0);
        chk("cs_hold_src0", 64'(src0), 64'h12);
        chk("cs_hold_busy", 64'(src0Busy), 64'd1);
        chk("cs_mask", 64'(busyMask), 64'h8);
        drive(0, 1, 5'd9, 5'd9, 0, 0, 0, 0, 0);
        chk("cs_x9", 64'(src0), 64'd0);
        chk("cs_x9_busy", 64'(src0Busy), 64'd0);

        random_traffic(3000);

        // Non-power-of-2 build: 64-bit data, 24 entries.
        idle();
        p_wrEn = 1; p_selDst = 5'd23; p_dst = 64'h0123_4567_89AB_CDEF;
        p_rdEn = 1; p_selSrc0 = 5'd23; p_selSrc1 = 5'd0;
        pcyc();
        chk("p_bypass23", p_src0, 64'h0123_4567_89AB_CDEF);
        chk("p_valid", 64'(p_srcValid), 64'd1);
        p_wrEn = 0; p_selSrc0 = 5'd0; p_selSrc1 = 5'd23;
        pcyc();
        chk("p_stored23", p_src1, 64'h0123_4567_89AB_CDEF);
        p_wrEn = 1; p_selDst = 5'd30; p_dst = '1; p_rsvEn = 1; p_selRsv = 5'd30;
        p_selSrc0 = 5'd30; p_selSrc1 = 5'd30;
        pcyc();
        chk("p_oor_bypass", p_src0, 64'd0);
        chk("p_oor_mask", 64'(p_busyMask), 64'd0);
        p_wrEn = 0; p_selRsv = 5'd23; p_selSrc1 = 5'd23;
        pcyc();
        chk("p_oor_read", p_src0, 64'd0);
        chk("p_rsv23_mask", 64'(p_busyMask), 64'h80_0000);
        chk("p_rsv23_busy", 64'(p_src1Busy), 64'd1);
        chk("p_x23_kept", p_src1, 64'h0123_4567_89AB_CDEF);
        p_rsvEn = 0; p_rdEn = 0;
        pcyc();
        chk("p_idle_valid", 64'(p_srcValid), 64'd0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
